// File: rtl/sys_ctrl_burst_pkg.sv
// Shared definitions for the burst command controller.
// Holds the opcode bytes, the one-hot state encoding, the reset state and the opcode decoder.
package sys_ctrl_burst_pkg;

   localparam logic [7:0] OPC_WRITE   = 8'hAA;
   localparam logic [7:0] OPC_READ    = 8'hBB;
   localparam logic [7:0] OPC_ALU_OP  = 8'hCC;
   localparam logic [7:0] OPC_ALU     = 8'hDD;
   localparam logic [7:0] OPC_BWRITE  = 8'hEE;
   localparam logic [7:0] OPC_BREAD   = 8'hFF;

   typedef enum logic [10:0] {
      IDLE     = 11'h001,
      ADDR     = 11'h002,
      CNT      = 11'h004,
      WDATA    = 11'h008,
      RD_ISSUE = 11'h010,
      RD_WAIT  = 11'h020,
      PUSH     = 11'h040,
      OP_A     = 11'h080,
      OP_B     = 11'h100,
      FUN      = 11'h200,
      ALU_WAIT = 11'h400
   } state_t;

   typedef enum logic [2:0] {
      CMD_BAD,
      CMD_WRITE,
      CMD_READ,
      CMD_BWRITE,
      CMD_BREAD,
      CMD_ALU_OP,
      CMD_ALU
   } cmd_t;

   localparam state_t ST_RESET = IDLE;

   function automatic cmd_t decode_opcode(input logic [7:0] opc);
      cmd_t cmd;
      cmd = CMD_BAD;
      case (opc)
         OPC_WRITE:  cmd = CMD_WRITE;
         OPC_READ:   cmd = CMD_READ;
         OPC_BWRITE: cmd = CMD_BWRITE;
         OPC_BREAD:  cmd = CMD_BREAD;
         OPC_ALU_OP: cmd = CMD_ALU_OP;
         OPC_ALU:    cmd = CMD_ALU;
         default:    cmd = CMD_BAD;
      endcase
      return cmd;
   endfunction

endpackage

// File: rtl/sys_ctrl_timeout.sv
// Idle-cycle watchdog for frames that stall while waiting for input.
// A limit of 0 disables expiry entirely.
module sys_ctrl_timeout #(
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic CLK,
   input  logic RST,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = $clog2(TIMEOUT_CYCLES + 2);
   localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

   logic [CW-1:0] count;

   // Restart on clear, advance only while enabled, and saturate at the limit.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST)
         count <= '0;
      else if (clear)
         count <= '0;
      else if (enable && (count != LIMIT))
         count <= count + 1'b1;
   end

   assign expired = (TIMEOUT_CYCLES != 0) && enable && (count == LIMIT);

endmodule

// File: rtl/sys_ctrl_burst.sv
// Command controller: decodes UART frames into register-file reads/writes, bursts and ALU
// operations, and serialises read data or ALU results into the TX FIFO.
module sys_ctrl_burst
   import sys_ctrl_burst_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int ADDR_WIDTH     = 4,
   parameter int FUN_WIDTH      = 4,
   parameter int RES_WIDTH      = 16,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic [DATA_WIDTH-1:0] RX_P_Data,
   input  logic                  RX_D_VLD,
   input  logic                  FIFO_FULL,
   input  logic [RES_WIDTH-1:0]  ALU_OUT,
   input  logic                  OUT_Valid,
   input  logic [DATA_WIDTH-1:0] RdData,
   input  logic                  RdData_Valid,
   output logic                  WR_INC,
   output logic [DATA_WIDTH-1:0] WrData_FIFO,
   output logic                  ALU_EN,
   output logic [FUN_WIDTH-1:0]  ALU_FUN,
   output logic [ADDR_WIDTH-1:0] Address,
   output logic                  WrEn,
   output logic                  RdEn,
   output logic [DATA_WIDTH-1:0] WrData,
   output logic                  Gate_EN,
   output logic                  clk_div_en,
   output logic                  busy,
   output logic                  cmd_err
);

   localparam logic [DATA_WIDTH-1:0] ONE_BEAT  = DATA_WIDTH'(1);
   localparam logic [DATA_WIDTH-1:0] RES_BYTES = DATA_WIDTH'(RES_WIDTH / DATA_WIDTH);

   state_t                  state, state_next;
   logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
   logic [DATA_WIDTH-1:0]   count_q, count_d;
   logic [RES_WIDTH-1:0]    hold_q, hold_d;
   logic                    burst_q, burst_d;
   logic                    read_q, read_d;
   logic                    alu_q, alu_d;
   logic                    err_d;
   logic                    to_clear, to_enable, to_expired;
   logic [7:0]              rx_byte;

   assign rx_byte    = RX_P_Data[7:0];
   assign clk_div_en = 1'b1;

   assign to_enable = state inside {ADDR, CNT, WDATA, OP_A, OP_B, FUN, RD_WAIT, ALU_WAIT};
   assign to_clear  = RX_D_VLD || (state_next != state);

   sys_ctrl_timeout #(
      .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
   ) u_timeout (
      .CLK    (CLK),
      .RST    (RST),
      .clear  (to_clear),
      .enable (to_enable),
      .expired(to_expired)
   );

   // State, frame context and the registered status flags.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state   <= ST_RESET;
         addr_q  <= '0;
         count_q <= '0;
         hold_q  <= '0;
         burst_q <= 1'b0;
         read_q  <= 1'b0;
         alu_q   <= 1'b0;
         busy    <= 1'b0;
         cmd_err <= 1'b0;
      end else begin
         state   <= state_next;
         addr_q  <= addr_d;
         count_q <= count_d;
         hold_q  <= hold_d;
         burst_q <= burst_d;
         read_q  <= read_d;
         alu_q   <= alu_d;
         busy    <= (state_next != IDLE);
         cmd_err <= err_d;
      end
   end

   // Frame sequencing and strobes; bytes arriving in non-receiving states are dropped.
   always_comb begin
      state_next  = state;
      addr_d      = addr_q;
      count_d     = count_q;
      hold_d      = hold_q;
      burst_d     = burst_q;
      read_d      = read_q;
      alu_d       = alu_q;
      err_d       = 1'b0;
      WR_INC      = 1'b0;
      WrData_FIFO = '0;
      ALU_EN      = 1'b0;
      ALU_FUN     = '0;
      Address     = '0;
      WrEn        = 1'b0;
      RdEn        = 1'b0;
      WrData      = '0;
      Gate_EN     = 1'b0;
      unique case (state)
         IDLE: begin
            if (RX_D_VLD) begin
               burst_d = 1'b0;
               read_d  = 1'b0;
               alu_d   = 1'b0;
               case (decode_opcode(rx_byte))
                  CMD_WRITE:  state_next = ADDR;
                  CMD_READ:   begin read_d = 1'b1; state_next = ADDR; end
                  CMD_BWRITE: begin burst_d = 1'b1; state_next = ADDR; end
                  CMD_BREAD:  begin burst_d = 1'b1; read_d = 1'b1; state_next = ADDR; end
                  CMD_ALU_OP: state_next = OP_A;
                  CMD_ALU:    state_next = FUN;
                  default:    err_d = 1'b1;
               endcase
            end
         end
         ADDR: begin
            if (RX_D_VLD) begin
               addr_d  = RX_P_Data[ADDR_WIDTH-1:0];
               count_d = ONE_BEAT;
               if (burst_q)     state_next = CNT;
               else if (read_q) state_next = RD_ISSUE;
               else             state_next = WDATA;
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         CNT: begin
            if (RX_D_VLD) begin
               if (RX_P_Data == '0) begin
                  err_d      = 1'b1;
                  state_next = IDLE;
               end else begin
                  count_d    = RX_P_Data;
                  state_next = read_q ? RD_ISSUE : WDATA;
               end
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         WDATA: begin
            if (RX_D_VLD) begin
               WrEn    = 1'b1;
               Address = addr_q;
               WrData  = RX_P_Data;
               addr_d  = addr_q + 1'b1;
               count_d = count_q - 1'b1;
               if (count_q == ONE_BEAT) state_next = IDLE;
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         RD_ISSUE: begin
            RdEn       = 1'b1;
            Address    = addr_q;
            state_next = RD_WAIT;
         end
         RD_WAIT: begin
            if (RdData_Valid) begin
               hold_d     = RES_WIDTH'(RdData);
               state_next = PUSH;
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         PUSH: begin
            Gate_EN     = alu_q;
            WrData_FIFO = hold_q[DATA_WIDTH-1:0];
            if (!FIFO_FULL) begin
               WR_INC  = 1'b1;
               count_d = count_q - 1'b1;
               if (alu_q) hold_d = hold_q >> DATA_WIDTH;
               if (count_q == ONE_BEAT) begin
                  state_next = IDLE;
               end else if (!alu_q) begin
                  addr_d     = addr_q + 1'b1;
                  state_next = RD_ISSUE;
               end
            end
         end
         OP_A: begin
            if (RX_D_VLD) begin
               WrEn       = 1'b1;
               Address    = '0;
               WrData     = RX_P_Data;
               state_next = OP_B;
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         OP_B: begin
            if (RX_D_VLD) begin
               WrEn       = 1'b1;
               Address    = ADDR_WIDTH'(1);
               WrData     = RX_P_Data;
               state_next = FUN;
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         FUN: begin
            Gate_EN = 1'b1;
            if (RX_D_VLD) begin
               ALU_EN     = 1'b1;
               ALU_FUN    = RX_P_Data[FUN_WIDTH-1:0];
               state_next = ALU_WAIT;
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         ALU_WAIT: begin
            Gate_EN = 1'b1;
            if (OUT_Valid) begin
               hold_d     = ALU_OUT;
               count_d    = RES_BYTES;
               alu_d      = 1'b1;
               state_next = PUSH;
            end else if (to_expired) begin
               err_d      = 1'b1;
               state_next = IDLE;
            end
         end
         default: state_next = IDLE;
      endcase
   end

endmodule

// File: tb/tb_sys_ctrl_burst.sv
// Directed bench for sys_ctrl_burst: a cycle table for the simple frames plus hand-written
// sequences for burst read with backpressure, ALU serialisation, timeout and mid-frame reset.
module tb_sys_ctrl_burst;

   localparam int TO = 255;

   logic        CLK;
   logic        RST;
   logic [7:0]  RX_P_Data;
   logic        RX_D_VLD;
   logic        FIFO_FULL;
   logic [15:0] ALU_OUT;
   logic        OUT_Valid;
   logic [7:0]  RdData;
   logic        RdData_Valid;
   logic        WR_INC;
   logic [7:0]  WrData_FIFO;
   logic        ALU_EN;
   logic [3:0]  ALU_FUN;
   logic [3:0]  Address;
   logic        WrEn;
   logic        RdEn;
   logic [7:0]  WrData;
   logic        Gate_EN;
   logic        clk_div_en;
   logic        busy;
   logic        cmd_err;

   typedef struct packed {
      logic       wr_inc;
      logic [7:0] fifo_data;
      logic       alu_en;
      logic [3:0] alu_fun;
      logic [3:0] addr;
      logic       wr_en;
      logic       rd_en;
      logic [7:0] wr_data;
      logic       gate_en;
      logic       busy;
      logic       cmd_err;
   } obs_t;

   typedef struct {
      logic       vld;
      logic [7:0] data;
      logic       full;
      logic       rd_vld;
      logic [7:0] rd_data;
      obs_t       exp;
   } vec_t;

   obs_t  obs;
   vec_t  tbl[$];
   int    n_checks = 0;
   int    n_fails  = 0;

   assign obs = {WR_INC, WrData_FIFO, ALU_EN, ALU_FUN, Address, WrEn, RdEn, WrData,
                 Gate_EN, busy, cmd_err};

   sys_ctrl_burst dut (
      .CLK         (CLK),
      .RST         (RST),
      .RX_P_Data   (RX_P_Data),
      .RX_D_VLD    (RX_D_VLD),
      .FIFO_FULL   (FIFO_FULL),
      .ALU_OUT     (ALU_OUT),
      .OUT_Valid   (OUT_Valid),
      .RdData      (RdData),
      .RdData_Valid(RdData_Valid),
      .WR_INC      (WR_INC),
      .WrData_FIFO (WrData_FIFO),
      .ALU_EN      (ALU_EN),
      .ALU_FUN     (ALU_FUN),
      .Address     (Address),
      .WrEn        (WrEn),
      .RdEn        (RdEn),
      .WrData      (WrData),
      .Gate_EN     (Gate_EN),
      .clk_div_en  (clk_div_en),
      .busy        (busy),
      .cmd_err     (cmd_err)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fails++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic vld, input logic [7:0] data, input logic full,
                        input logic ovld, input logic rvld, input logic [7:0] rdat);
      @(negedge CLK);
      RX_D_VLD     = vld;
      RX_P_Data    = data;
      FIFO_FULL    = full;
      OUT_Valid    = ovld;
      RdData_Valid = rvld;
      RdData       = rdat;
      #2;
   endtask

   task automatic beat(input logic [7:0] b);
      drive(1'b1, b, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic gap();
      drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic applyStimulus(input vec_t v);
      drive(v.vld, v.data, v.full, 1'b0, v.rd_vld, v.rd_data);
   endtask

   function automatic vec_t mkv(input logic vld, input logic [7:0] data, input logic busy_e,
                                input logic err_e);
      vec_t v;
      v.vld         = vld;
      v.data        = data;
      v.full        = 1'b0;
      v.rd_vld      = 1'b0;
      v.rd_data     = 8'h00;
      v.exp         = '0;
      v.exp.busy    = busy_e;
      v.exp.cmd_err = err_e;
      return v;
   endfunction

   function automatic vec_t mkWr(input logic [7:0] data, input logic [3:0] a);
      vec_t v;
      v = mkv(1'b1, data, 1'b1, 1'b0);
      v.exp.wr_en   = 1'b1;
      v.exp.addr    = a;
      v.exp.wr_data = data;
      return v;
   endfunction

   initial begin
      vec_t        v;
      logic [7:0]  mem [16];
      logic [7:0]  exp_push [2];
      logic [3:0]  exp_raddr [2];
      logic [3:0]  ra;
      logic        rdp;
      logic        full;
      logic        got;
      int          nrden, npush, nfull_push, lat;

      RST = 1'b0; RX_D_VLD = 1'b0; RX_P_Data = '0; FIFO_FULL = 1'b0;
      ALU_OUT = '0; OUT_Valid = 1'b0; RdData = '0; RdData_Valid = 1'b0;
      for (int i = 0; i < 16; i++) mem[i] = 8'h00;
      mem[2] = 8'hA1;
      mem[3] = 8'hB2;
      exp_push[0]  = 8'hA1; exp_push[1]  = 8'hB2;
      exp_raddr[0] = 4'h2;  exp_raddr[1] = 4'h3;

      // Cycle table: single write, burst write with wrap, bad opcode, zero count, single read
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'hAA, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'h03, 1'b1, 1'b0));
      tbl.push_back(mkWr(8'h5A, 4'h3));
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'hEE, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'h0E, 1'b1, 1'b0));
      tbl.push_back(mkv(1'b1, 8'h03, 1'b1, 1'b0));
      tbl.push_back(mkWr(8'h11, 4'hE));
      tbl.push_back(mkWr(8'h22, 4'hF));
      tbl.push_back(mkWr(8'h33, 4'h0));
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'h42, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b1));
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'hEE, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'h05, 1'b1, 1'b0));
      tbl.push_back(mkv(1'b1, 8'h00, 1'b1, 1'b0));
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b1));
      tbl.push_back(mkv(1'b1, 8'hBB, 1'b0, 1'b0));
      tbl.push_back(mkv(1'b1, 8'h07, 1'b1, 1'b0));
      v = mkv(1'b0, 8'h00, 1'b1, 1'b0); v.exp.rd_en = 1'b1; v.exp.addr = 4'h7;
      tbl.push_back(v);
      v = mkv(1'b0, 8'h00, 1'b1, 1'b0); v.rd_vld = 1'b1; v.rd_data = 8'h9C;
      tbl.push_back(v);
      v = mkv(1'b0, 8'h00, 1'b1, 1'b0); v.exp.wr_inc = 1'b1; v.exp.fifo_data = 8'h9C;
      tbl.push_back(v);
      tbl.push_back(mkv(1'b0, 8'h00, 1'b0, 1'b0));

      // Reset state
      #12;
      checkOutput("reset outputs", obs, '0);
      checkOutput("reset clk_div_en", clk_div_en, 1);
      @(negedge CLK);
      RST = 1'b1;

      foreach (tbl[i]) begin
         applyStimulus(tbl[i]);
         checkOutput($sformatf("vector %0d", i), obs, tbl[i].exp);
      end

      // Burst read of two bytes from address 2 with the FIFO full for five cycles
      beat(8'hFF);
      beat(8'h02);
      beat(8'h02);
      rdp = 1'b0; ra = '0; nrden = 0; npush = 0; nfull_push = 0;
      for (int c = 0; c < 40 && npush < 2; c++) begin
         full = (c >= 2 && c <= 6);
         drive(1'b0, 8'h00, full, 1'b0, rdp, rdp ? mem[ra] : 8'h00);
         if (RdEn) begin
            if (nrden < 2) checkOutput("burst read address", Address, exp_raddr[nrden]);
            nrden++;
            ra = Address;
         end
         rdp = RdEn;
         if (full && c >= 3) checkOutput("burst read held data", WrData_FIFO, 8'hA1);
         if (full && WR_INC) nfull_push++;
         if (WR_INC) begin
            if (npush < 2) checkOutput("burst read push data", WrData_FIFO, exp_push[npush]);
            npush++;
         end
      end
      checkOutput("burst read RdEn count", nrden, 2);
      checkOutput("burst read push count", npush, 2);
      checkOutput("burst read push while full", nfull_push, 0);
      gap();
      checkOutput("burst read idle busy", busy, 0);

      // ALU with operands: reg0=7, reg1=5, function 0, result 0x000C pushed LSB first
      ALU_OUT = 16'h000C;
      beat(8'hCC);
      beat(8'h07);
      checkOutput("alu op A write", {WrEn, Address, WrData}, {1'b1, 4'h0, 8'h07});
      beat(8'h05);
      checkOutput("alu op B write", {WrEn, Address, WrData}, {1'b1, 4'h1, 8'h05});
      beat(8'h00);
      checkOutput("alu fun strobe", {ALU_EN, ALU_FUN, Gate_EN}, {1'b1, 4'h0, 1'b1});
      drive(1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h00);
      checkOutput("alu wait gate", {WR_INC, Gate_EN, busy}, {1'b0, 1'b1, 1'b1});
      gap();
      checkOutput("alu push byte 0", {WR_INC, WrData_FIFO, Gate_EN}, {1'b1, 8'h0C, 1'b1});
      gap();
      checkOutput("alu push byte 1", {WR_INC, WrData_FIFO, Gate_EN}, {1'b1, 8'h00, 1'b1});
      gap();
      checkOutput("alu done", {WR_INC, Gate_EN, busy}, {1'b0, 1'b0, 1'b0});

      // Timeout: write opcode followed by silence
      beat(8'hAA);
      got = 1'b0; lat = 0;
      for (int c = 1; c <= 400 && !got; c++) begin
         gap();
         if (cmd_err) begin
            got = 1'b1;
            lat = c;
         end
      end
      checkOutput("timeout fired", got, 1);
      checkOutput("timeout latency in range", (lat >= TO && lat <= TO + 3), 1);
      checkOutput("timeout back to idle", busy, 0);

      // Reset while pushing an ALU result, then a fresh write frame
      ALU_OUT = 16'hA55A;
      beat(8'hDD);
      beat(8'h03);
      checkOutput("dd fun strobe", {ALU_EN, ALU_FUN}, {1'b1, 4'h3});
      drive(1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00);
      drive(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00);
      checkOutput("stalled push", {WR_INC, WrData_FIFO, Gate_EN}, {1'b0, 8'h5A, 1'b1});
      gap();
      checkOutput("push before reset", {WR_INC, WrData_FIFO}, {1'b1, 8'h5A});
      RST = 1'b0;
      #1;
      checkOutput("async reset strobes", obs, '0);
      checkOutput("async reset clk_div_en", clk_div_en, 1);
      @(negedge CLK);
      checkOutput("held reset strobes", obs, '0);
      RST = 1'b1;
      beat(8'hAA);
      beat(8'h09);
      beat(8'h3C);
      checkOutput("post reset write", {WrEn, Address, WrData}, {1'b1, 4'h9, 8'h3C});
      gap();
      checkOutput("post reset idle", {busy, cmd_err}, {1'b0, 1'b0});

      $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/sys_ctrl_burst.md
# sys_ctrl_burst

Parametrised command controller between the RX data synchronizer and the register file, ALU and TX FIFO. It decodes UART command frames, including single-register read/write, ALU with or without operands, and burst read/write with address auto-increment. It serialises a parametrised-width ALU result into the FIFO and aborts stalled frames on timeout. Runs in the reference clock domain.

## Interface
- DATA_WIDTH, 8, frame / register data width
- ADDR_WIDTH, 4, register-file address width
- FUN_WIDTH, 4, ALU function width
- RES_WIDTH, 16, ALU result width; integer multiple of DATA_WIDTH
- TIMEOUT_CYCLES, 255, idle-cycle limit while waiting mid-frame; 0 disables
- CLK  in  1  clock
- RST  in  1  reset, asynchronous, active-low
- RX_P_Data  in  DATA_WIDTH  received frame byte
- RX_D_VLD  in  1  one-cycle valid for RX_P_Data
- FIFO_FULL  in  1  TX FIFO full
- ALU_OUT  in  RES_WIDTH  ALU result
- OUT_Valid  in  1  ALU result valid
- RdData  in  DATA_WIDTH  register-file read data
- RdData_Valid  in  1  read data valid
- WR_INC  out  1  FIFO push strobe
- WrData_FIFO  out  DATA_WIDTH  FIFO push data
- ALU_EN  out  1  ALU enable
- ALU_FUN  out  FUN_WIDTH  ALU function
- Address  out  ADDR_WIDTH  register-file address
- WrEn  out  1  register write strobe
- RdEn  out  1  register read strobe
- WrData  out  DATA_WIDTH  register write data
- Gate_EN  out  1  ALU clock-gate enable
- clk_div_en  out  1  clock divider enable; constant 1
- busy  out  1  high whenever state is not IDLE
- cmd_err  out  1  one-cycle pulse on unknown opcode, zero count, or timeout

## Operation
- Opcodes, decoded in IDLE on RX_D_VLD:
  - 0xAA: write, count 1
  - 0xBB: read, count 1
  - 0xEE: burst write, explicit count byte
  - 0xFF: burst read, explicit count byte
  - 0xCC: ALU with operands A, B
  - 0xDD: ALU without operands
  - Any other byte: cmd_err, stay IDLE.
- States: IDLE, ADDR, CNT, WDATA, RD_ISSUE, RD_WAIT, PUSH, OP_A, OP_B, FUN, ALU_WAIT.
- Write (AA/EE): ADDR latches addr, then EE goes to CNT, which latches N. WDATA:
  - Each RX beat drives WrEn=1, Address=addr, WrData=RX_P_Data combinationally in the beat cycle.
  - addr increments modulo 2^ADDR_WIDTH. After N beats → IDLE.
- Read (BB/FF): ADDR → (CNT) → RD_ISSUE → RD_WAIT → PUSH loop:
  - RD_ISSUE: RdEn=1 with Address=addr for exactly one cycle.
  - RD_WAIT: on RdData_Valid, capture RdData into a holding register.
  - PUSH: WR_INC=1 with the held byte when !FIFO_FULL. Then either increment addr and return to RD_ISSUE, or go IDLE after N bytes.
- Count byte 0 → cmd_err, IDLE; no accesses. Address wrap is silent.
- ALU with operands (CC): OP_A writes reg 0 and OP_B writes reg 1, as in the write path. Then FUN.
- FUN (also reached directly from DD): on the beat, ALU_EN=1 with ALU_FUN=RX_P_Data[FUN_WIDTH-1:0] for one cycle → ALU_WAIT.
- ALU_WAIT: on OUT_Valid, capture ALU_OUT → PUSH. PUSH emits RES_WIDTH/DATA_WIDTH bytes, LSB first, one per cycle when !FIFO_FULL, then → IDLE.
- Gate_EN=1 in FUN, ALU_WAIT, and ALU-result PUSH; 0 otherwise.
- Timeout:
  - Counter clears on state entry and on every RX_D_VLD.
  - It increments in ADDR, CNT, WDATA, OP_A, OP_B, FUN, RD_WAIT, ALU_WAIT.
  - On reaching TIMEOUT_CYCLES: cmd_err pulse, → IDLE.
  - PUSH never times out; FIFO backpressure is legitimate.
- RX_D_VLD is ignored in RD_ISSUE, RD_WAIT, PUSH and ALU_WAIT. Those bytes are dropped, not buffered.

## Timing
- Reset: all outputs 0 except clk_div_en=1; state IDLE; counters and holding registers 0. Reset mid-frame aborts with no further strobes.
- Write: WrEn in the same cycle as the data beat.
- Read: RdEn one cycle after the address beat (or count beat). FIFO push no earlier than the cycle after RdData_Valid.
- ALU: ALU_EN in the FUN beat cycle. First push no earlier than the cycle after OUT_Valid. Bytes are consecutive when FIFO is not full.
- FIFO_FULL is sampled each PUSH cycle. When full: WR_INC=0 and data held.
- cmd_err and busy are registered.

## Structure
- Shared package: opcode constants, state encoding (one-hot), reset values.
- Sub-module: sys_ctrl_timeout (counter, clear, expire).

## Test plan
- Write: AA, 0x03, 0x5A → one WrEn, Address=3, WrData=0x5A; back to IDLE.
- Burst write: EE, 0x0E, 0x03, 11, 22, 33 → writes to addresses 14, 15, 0 (wrap); busy low after the third.
- Burst read: FF, 0x02, 0x02, with FIFO_FULL high 5 cycles → two RdEn, two pushes in order, no push while full.
- ALU with operands: CC, 0x07, 0x05, 0x00; ALU_OUT=0x000C with OUT_Valid → reg0=7, reg1=5, pushes 0x0C then 0x00.
- Errors: opcode 0x42 → cmd_err only. AA then silence for TIMEOUT_CYCLES → cmd_err, IDLE. EE count 0 → cmd_err.
- RST asserted during PUSH → all strobes 0 immediately; after release, a fresh AA frame works.
